// File: rtl/rot_share_arbiter.sv
// Round-robin arbiter that shares one 4-bit rotate-right unit between two
// requesters. Each operation goes through grant, rotate and a done/ack
// handshake. A saturating counter tracks how many operations completed.
module rot_share_arbiter #(
  parameter bit PRIO_INIT = 1'b0,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [3:0]    a0,
  input  logic [1:0]    sh0,
  input  logic          ack0,
  input  logic          req1,
  input  logic [3:0]    a1,
  input  logic [1:0]    sh1,
  input  logic          ack1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [3:0]    y,
  output logic          busy,
  output logic [CW-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ROT, RESP} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic [3:0]    a_lat_q, a_lat_d;
  logic [1:0]    sh_lat_q, sh_lat_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic [3:0]    y_q, y_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick;
  logic          owner_ack;

  // Mux-based rotate right: result bit i takes operand bit (i+sh) mod 4.
  function automatic logic [3:0] rotr(input logic [3:0] a, input logic [1:0] sh);
    case (sh)
      2'd0:    rotr = a;
      2'd1:    rotr = {a[0], a[3:1]};
      2'd2:    rotr = {a[1:0], a[3:2]};
      default: rotr = {a[2:0], a[3]};
    endcase
  endfunction

  // Next-state logic: arbitration in IDLE, rotate in ROT, handshake in RESP.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    a_lat_d   = a_lat_q;
    sh_lat_d  = sh_lat_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = done0_q;
    done1_d   = done1_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    pick      = (req0 && req1) ? ptr_q : req1;
    owner_ack = owner_q ? ack1 : ack0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d  = pick;
          a_lat_d  = pick ? a1 : a0;
          sh_lat_d = pick ? sh1 : sh0;
          gnt0_d   = !pick;
          gnt1_d   = pick;
          state_d  = ROT;
        end
      end
      ROT: begin
        y_d     = rotr(a_lat_q, sh_lat_q);
        done0_d = !owner_q;
        done1_d = owner_q;
        state_d = RESP;
      end
      RESP: begin
        if (owner_ack) begin
          done0_d = 1'b0;
          done1_d = 1'b0;
          ptr_d   = !owner_q;
          if (cnt_q != {CW{1'b1}}) begin
            cnt_d = cnt_q + CW'(1);
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset that aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PRIO_INIT;
      owner_q  <= 1'b0;
      a_lat_q  <= '0;
      sh_lat_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      a_lat_q  <= a_lat_d;
      sh_lat_q <= sh_lat_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign y        = y_q;
  assign busy     = busy_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_rot_share_arbiter.sv
// Scoreboard bench for rot_share_arbiter: requesters push expected rotate
// results into per-requester queues, and a negedge monitor with a behavioural
// model of the arbitration and handshake rules compares every output.
module tb_rot_share_arbiter;

  localparam int CW_TB   = 3;
  localparam bit PRIO_TB = 1'b0;
  localparam logic [CW_TB-1:0] CNT_MAX = {CW_TB{1'b1}};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [3:0]       a0 = '0, a1 = '0;
  logic [1:0]       sh0 = '0, sh1 = '0;
  logic             ack0 = 1'b0, ack1 = 1'b0;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [3:0]       y;
  logic [CW_TB-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];

  // Input snapshots taken at the active edge, so the monitor sees what the DUT sampled.
  logic       rst_snap = 1'b1;
  logic [1:0] req_snap = '0;
  logic [1:0] ack_snap = '0;

  // Behavioural model state.
  bit               m_idle = 1'b1;
  bit               m_fav  = PRIO_TB;
  logic [CW_TB-1:0] m_cnt  = '0;
  logic [3:0]       m_y    = '0;
  logic [1:0]       m_gnt  = '0;
  logic [1:0]       m_done = '0;
  logic [1:0]       g_new, d_new;

  rot_share_arbiter #(.PRIO_INIT(PRIO_TB), .CW(CW_TB)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .sh0(sh0), .ack0(ack0),
    .req1(req1), .a1(a1), .sh1(sh1), .ack1(ack1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .y(y), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Rotate right by sh, written as a shift of the doubled operand.
  function automatic logic [3:0] rot_ref(input logic [3:0] a, input logic [1:0] sh);
    logic [7:0] dbl;
    dbl = {a, a} >> sh;
    return dbl[3:0];
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic v);
    if (k == 0) req0 = v; else req1 = v;
  endtask

  task automatic set_ack(input int k, input logic v);
    if (k == 0) ack0 = v; else ack1 = v;
  endtask

  task automatic set_opnd(input int k, input logic [3:0] a, input logic [1:0] sh);
    if (k == 0) begin a0 = a; sh0 = sh; end
    else begin a1 = a; sh1 = sh; end
  endtask

  function automatic logic get_gnt(input int k);
    return (k == 0) ? gnt0 : gnt1;
  endfunction

  function automatic logic get_done(input int k);
    return (k == 0) ? done0 : done1;
  endfunction

  // Issues one operation for requester k (called at a negedge) and completes its handshake.
  task automatic applyStimulus(input int k, input logic [3:0] a, input logic [1:0] sh,
                               input int ack_dly, input bit hold);
    int cyc;
    if (k == 0) exp_q0.push_back(rot_ref(a, sh));
    else        exp_q1.push_back(rot_ref(a, sh));
    set_opnd(k, a, sh);
    set_req(k, 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!get_gnt(k) && cyc < 64);
    if (!get_gnt(k)) begin
      checkOutput("gnt_timeout", 0, 1);
      set_req(k, 1'b0);
      return;
    end
    if (!hold) set_req(k, 1'b0);
    set_opnd(k, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!get_done(k) && cyc < 8);
    if (!get_done(k)) begin
      checkOutput("done_timeout", 0, 1);
      return;
    end
    repeat (ack_dly) @(negedge clk);
    set_ack(k, 1'b1);
    @(negedge clk);
    set_ack(k, 1'b0);
  endtask

  // Runs a sequence of operations for requester k; held mode keeps req high between ops.
  task automatic runRequester(input int k, input int nops, input bit rand_mode);
    bit held;
    bit hold;
    int gap;
    held = 1'b0;
    for (int n = 0; n < nops; n++) begin
      if (rand_mode && !held) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin
          set_ack(k, 1'($urandom_range(0, 1)));
          @(negedge clk);
        end
        set_ack(k, 1'b0);
      end
      if (n == nops - 1) hold = 1'b0;
      else if (rand_mode) hold = 1'($urandom_range(0, 1));
      else hold = 1'b1;
      applyStimulus(k, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), hold);
      held = hold;
    end
  endtask

  // Capture what the DUT sees at each rising edge.
  always @(posedge clk) begin
    rst_snap <= rst;
    req_snap <= {req1, req0};
    ack_snap <= {ack1, ack0};
  end

  // Monitor: advance the model by one edge, then compare every output.
  always @(negedge clk) begin
    if (rst_snap) begin
      m_idle = 1'b1;
      m_fav  = PRIO_TB;
      m_cnt  = '0;
      m_y    = '0;
      m_gnt  = '0;
      m_done = '0;
    end else begin
      g_new = '0;
      if (m_idle && req_snap != 2'b00) begin
        if (req_snap == 2'b11) g_new[m_fav] = 1'b1;
        else g_new = req_snap;
        m_idle = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
        d_new[k] = m_gnt[k] || (m_done[k] && !ack_snap[k]);
        if (d_new[k] && !m_done[k]) begin
          if (k == 0 && exp_q0.size() > 0) m_y = exp_q0.pop_front();
          else if (k == 1 && exp_q1.size() > 0) m_y = exp_q1.pop_front();
          else checkOutput("scoreboard_empty", 0, 1);
        end
        if (m_done[k] && !d_new[k]) begin
          m_fav  = (k == 0);
          m_idle = 1'b1;
          if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
        end
      end
      m_gnt  = g_new;
      m_done = d_new;
    end
    checkOutput("gnt0", gnt0, m_gnt[0]);
    checkOutput("gnt1", gnt1, m_gnt[1]);
    checkOutput("done0", done0, m_done[0]);
    checkOutput("done1", done1, m_done[1]);
    checkOutput("y", y, m_y);
    checkOutput("busy", busy, !m_idle);
    checkOutput("op_count", op_count, m_cnt);
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Every rotate amount on one operand, acked at once.
    for (int s = 0; s < 4; s++) applyStimulus(0, 4'b1011, 2'(s), 0, 1'b0);
    repeat (2) @(negedge clk);

    // Abort an operation in ROT; no done must follow and the pointer returns to its initial value.
    set_opnd(1, 4'b0011, 2'd1);
    req1 = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!gnt1 && cyc < 16);
    checkOutput("abort_gnt1", gnt1, 1);
    rst  = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous requests after reset: requester 0 is served first.
    fork
      applyStimulus(0, 4'b0001, 2'd1, 0, 1'b0);
      applyStimulus(1, 4'b1000, 2'd3, 0, 1'b0);
    join
    repeat (2) @(negedge clk);

    // Held ack with stray acks from the non-owner.
    fork
      applyStimulus(1, 4'b0110, 2'd2, 5, 1'b0);
      begin
        repeat (4) @(negedge clk);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // Both requests held continuously: service alternates.
    fork
      runRequester(0, 3, 1'b0);
      runRequester(1, 3, 1'b0);
    join
    repeat (2) @(negedge clk);

    // Random traffic, well past counter saturation.
    fork
      runRequester(0, 20, 1'b1);
      runRequester(1, 20, 1'b1);
    join
    repeat (4) @(negedge clk);

    checkOutput("queue0_drained", exp_q0.size(), 0);
    checkOutput("queue1_drained", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rot_share_arbiter.md
Name: rot_share_arbiter

Overview:
- Shares one 4-bit rotate-right unit between two requesters.
- Round-robin arbitration, a grant pulse, a registered result, and a done/ack handshake per requester.
- Sits between two client datapaths and an internal copy of the mux-based 4-bit rotator.
- Counts completed operations for debug visibility.

Parameters:
- PRIO_INIT, 0: requester favoured first after reset (0 or 1).
- CW, 8: width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request; held high with a0/sh0 stable until gnt0.
- a0  input  4  requester 0 operand.
- sh0  input  2  requester 0 rotate-right amount (0..3).
- ack0  input  1  requester 0 accepts its result.
- req1  input  1  requester 1 request; same rules as req0.
- a1  input  4  requester 1 operand.
- sh1  input  2  requester 1 rotate-right amount.
- ack1  input  1  requester 1 accepts its result.
- gnt0  output  1  one-cycle pulse: requester 0 operands latched.
- gnt1  output  1  one-cycle pulse: requester 1 operands latched.
- done0  output  1  result on y is for requester 0; held until ack0.
- done1  output  1  result on y is for requester 1; held until ack1.
- y  output  4  registered rotate result.
- busy  output  1  high whenever state is not IDLE.
- op_count  output  CW  completed operations; saturates at all-ones.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, gnt0/gnt1/done0/done1 = 0, y = 0, busy = 0, op_count = 0, priority pointer = PRIO_INIT, operand latches = 0.
- Reset mid-operation aborts the operation. No done is issued for the in-flight request.
- Rotate function: y[i] = a[(i+sh) mod 4], i.e. rotate right by sh. sh = 0 passes the operand through.
- FSM state IDLE:
  - No req: remain in IDLE.
  - One req: grant it.
  - Both req: grant the requester named by the pointer.
  - On grant, latch the winner's a/sh and owner id, pulse gnt for the next cycle, go to ROT.
- FSM state ROT (one cycle): register y from the latched operands, set done of the owner, go to RESP.
- FSM state RESP:
  - y and done are held stable.
  - When the owner's ack is sampled high: clear done, point the pointer at the other requester, increment op_count (saturating), go to IDLE.
  - Ack from the non-owner is ignored.
- Timing:
  - Request sampled at edge N gives gnt high in cycle N+1 and done high from cycle N+2.
  - With ack high at the first RESP edge, done drops one cycle later.
  - Minimum spacing between grants is 3 cycles.
- Latched values:
  - y retains its last value in IDLE.
  - Operand changes after gnt have no effect on the in-flight result.
- A req asserted while its requester is being served is not considered until the FSM returns to IDLE. The pointer then favours the other requester, so a continuously requesting pair alternates 0,1,0,1.
- ack asserted while done is low has no effect.
- done0 and done1 are never high together; gnt0 and gnt1 are never high together.
- op_count at all-ones stays at all-ones.

Test Plan:
- Rotate amounts: reset, then req0 with a0=4'b1011 and sh0=0,1,2,3 in turn, acking immediately each time -> y = 1011, 1101, 1110, 0111. gnt0 pulses one cycle after each request edge, done0 follows a cycle later, op_count = 4.
- Contention: PRIO_INIT=0, req0 and req1 raised in the same cycle (a0=4'b0001 sh0=1, a1=4'b1000 sh1=3) and held -> gnt0 first, y=1000, done0. After ack0, gnt1, y=0001, done1. op_count = 2.
- Held ack: req1 with a1=4'b0110 sh1=2; ack1 withheld for 5 cycles -> done1 and y=1001 stable for all 5 cycles, busy=1. ack0 pulsed during the wait is ignored. Releasing ack1 returns to IDLE, busy=0.
- Reset mid-operation: rst asserted during ROT -> next cycle all outputs = 0, state IDLE, no done. The pointer returns to PRIO_INIT, so a simultaneous req0/req1 grants requester 0 first.
- Counter saturation: CW=2, 5 back-to-back completed ops -> op_count steps 1, 2, 3, 3, 3.
- Fairness: both reqs held high continuously for 6 operations -> grant order 0,1,0,1,0,1, no overlapping done.
